// File: rtl/vc_credit_sender.sv
// Credit-based sender feeding a remote queue over a ready-less link.
// Outstanding credits are fully drained before the link domain changes.
module vc_credit_sender #(
  parameter int p_msg_nbits   = 32,
  parameter int p_num_credits = 2,
  localparam int c_cnt_nbits  = $clog2(p_num_credits + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic                   in_domain,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic                   tx_val,
  output logic                   tx_domain,
  output logic [p_msg_nbits-1:0] tx_msg,
  input  logic                   credit_ret,
  output logic [c_cnt_nbits-1:0] credits,
  output logic                   overflow_err
);

  typedef enum logic [0:0] {
    ST_ACTIVE = 1'b0,
    ST_DRAIN  = 1'b1
  } state_t;

  localparam logic [c_cnt_nbits-1:0] CNT_FULL = c_cnt_nbits'(p_num_credits);
  localparam logic [c_cnt_nbits-1:0] CNT_ONE  = c_cnt_nbits'(1);
  localparam logic [c_cnt_nbits-1:0] CNT_ZERO = c_cnt_nbits'(0);

  state_t                   state_r;
  logic [c_cnt_nbits-1:0]   credits_r;
  logic                     tx_val_r;
  logic                     tx_domain_r;
  logic [p_msg_nbits-1:0]   tx_msg_r;
  logic                     overflow_r;
  logic                     domain_ok_s;
  logic                     rdy_s;
  logic                     accept_s;

  // in_rdy never depends on credit_ret: only registered state and the domain compare
  assign domain_ok_s = (in_domain == tx_domain_r);
  assign rdy_s       = (state_r == ST_ACTIVE) && domain_ok_s && (credits_r != CNT_ZERO);
  assign accept_s    = in_val && rdy_s;

  // Link register, credit counter and drain/active control
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_ACTIVE;
      credits_r   <= CNT_FULL;
      tx_val_r    <= 1'b0;
      tx_domain_r <= 1'b0;
      tx_msg_r    <= {p_msg_nbits{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      tx_val_r <= accept_s;
      if (accept_s) begin
        tx_msg_r <= in_msg;
      end else begin
        tx_msg_r <= tx_msg_r;
      end

      case ({accept_s, credit_ret})
        2'b10: credits_r <= credits_r - CNT_ONE;
        2'b01: begin
          // A return at full count is a receiver protocol error: hold and flag
          if (credits_r == CNT_FULL) begin
            overflow_r <= 1'b1;
          end else begin
            credits_r <= credits_r + CNT_ONE;
          end
        end
        default: credits_r <= credits_r;
      endcase

      case (state_r)
        ST_ACTIVE: begin
          if (in_val && !domain_ok_s) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_ACTIVE;
          end
        end
        ST_DRAIN: begin
          if (in_val && (credits_r == CNT_FULL)) begin
            tx_domain_r <= in_domain;
            state_r     <= ST_ACTIVE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: state_r <= ST_ACTIVE;
      endcase
    end
  end

  assign in_rdy       = rdy_s;
  assign tx_val       = tx_val_r;
  assign tx_domain    = tx_domain_r;
  assign tx_msg       = tx_msg_r;
  assign credits      = credits_r;
  assign overflow_err = overflow_r;

endmodule

// File: doc/vc_credit_sender.md
# vc_credit_sender

Credit-based transmitter that drives messages into a remote `vc_Queue` receiver over a channel with no ready signal. It accepts messages from a local producer on a val/rdy interface and forwards each one on a registered one-way `tx_*` link. It tracks free receiver entries with a credit counter that is replenished by per-dequeue credit returns. When the security domain changes, it drains every outstanding credit before forwarding data of the new domain, so messages of different domains never coexist in the receiver queue.

## Interface
- `p_msg_nbits`, 32: message width in bits.
- `p_num_credits`, 2: receiver queue depth, which is also the initial credit count. Must be ≥1.
- `c_cnt_nbits`, `$clog2(p_num_credits+1)`: credit counter width. Local; do not override.

Ports, with security labels in braces:
- `clk`  in  1  clock. `{L}`
- `reset`  in  1  reset. One clock; reset is synchronous and active-high.
- `in_val`  in  1  producer message valid. `{Control in_domain}`
- `in_rdy`  out  1  sender accepts this cycle. `{Control in_domain}`
- `in_domain`  in  1  domain of `in_msg`. `{Control in_domain}`
- `in_msg`  in  `p_msg_nbits`  producer message. `{Domain in_domain}`
- `tx_val`  out  1  message valid on the link. Pulses for one cycle per message. `{Control tx_domain}`
- `tx_domain`  out  1  current link domain. `{L}`, changes only when the link is drained.
- `tx_msg`  out  `p_msg_nbits`  link message. `{Domain tx_domain}`
- `credit_ret`  in  1  receiver dequeued one entry this cycle. `{L}`
- `credits`  out  `c_cnt_nbits`  current credit count. `{L}`
- `overflow_err`  out  1  sticky; a credit was returned while the counter was full. `{L}`

## Operation
- **State machine, ACTIVE:**
  - `in_rdy = in_val_ok && (credits != 0)`, where `in_val_ok = (in_domain == tx_domain)`.
  - If `in_val && in_domain != tx_domain`, go to DRAIN next cycle. Nothing is accepted that cycle.
- **State machine, DRAIN:**
  - `in_rdy = 0`.
  - When `credits == p_num_credits` (registered value): set `tx_domain <= in_domain`, then go to ACTIVE next cycle.
  - If `in_val` has dropped, stay in DRAIN until `in_val` returns.
- **Accept:** a message is accepted when `in_val && in_rdy`.
- **Credit counter:** `credits_next = credits - accept + credit_ret`.
  - Accept and `credit_ret` in the same cycle leave the count unchanged.
  - If `credit_ret` arrives with no accept while `credits == p_num_credits`: the count holds at `p_num_credits` and `overflow_err` is set to 1.
  - `overflow_err` clears only on reset.
- **Underflow:** impossible by construction, because no accept can occur at `credits == 0`.
- **`credit_ret` in DRAIN:** counts normally.
- **`tx_msg`:** holds its last value when `tx_val = 0`.
- **Reset values:** state ACTIVE, `credits = p_num_credits`, `tx_val = 0`, `tx_msg = 0`, `tx_domain = 0`, `overflow_err = 0`.

## Timing
- **Accept latency:** accept at cycle N gives `tx_val = 1` and `tx_msg = in_msg(N)` at N+1, and `credits` decremented at N+1.
- **Back-to-back:** accepts are allowed every cycle while credits last. `tx_val` can stay high on consecutive cycles.
- **`credit_ret` latency:** a return at N is visible in `credits` at N+1. An accept can use that credit at N+1, so the return-to-send turnaround is one cycle.
- **`in_rdy`:** combinational from registered state and `credits`, plus a combinational compare against `in_domain`. There is no path from `credit_ret` to `in_rdy`.
- **Domain switch with the counter full:**
  - Mismatch seen at cycle N puts the block in DRAIN at N+1.
  - The full counter is detected at N+1, so `tx_domain` updates and the block is ACTIVE at N+2.
  - First new-domain accept at N+2; minimum penalty is 2 cycles.
- **Reset mid-operation:** all state returns to reset values at the next edge.
  - In-flight credits are forgotten, so the receiver must be reset in the same cycle.
  - `tx_val` is 0 in the cycle after reset.

## Test plan
1. **Reset values:** assert reset for 2 cycles with `p_num_credits = 2` → `credits = 2`, `tx_val = 0`, `tx_domain = 0`, `overflow_err = 0`, `in_rdy = 1` when `in_val = 1` and `in_domain = 0`.
2. **Credit exhaustion:** hold `in_val = 1` with messages 0xA, 0xB, 0xC, no returns → `tx_msg` = 0xA then 0xB on consecutive cycles, `credits` goes 1 then 0, `in_rdy = 0` on the third message. Pulse `credit_ret` → 0xC accepted the next cycle and appears one cycle later.
3. **Simultaneous accept and return:** at `credits = 1`, accept and pulse `credit_ret` in the same cycle → `credits` stays 1, `tx_val = 1` next cycle.
4. **Domain switch with outstanding credits:** send 2 messages in domain 0, then present `in_domain = 1` → DRAIN, `in_rdy = 0`, `tx_domain = 0` until 2 returns are received. Then `tx_domain = 1` and the domain-1 message is sent; no domain-1 `tx_val` appears while `credits < 2`.
5. **Overflow:** pulse `credit_ret` at `credits = 2` with no accept → `credits` stays 2, `overflow_err = 1`, and it persists until reset.
6. **Reset mid-drain:** enter DRAIN with `credits = 0`, then assert reset → the next cycle shows state ACTIVE, `credits = 2`, `tx_domain = 0`, `tx_val = 0`.
